mmio_bus: RTL and testbench

Memory-system block on the core's single memory port, downstream of the core. Decodes each core address into a word RAM (instructions and data), a UART transmitter with a small TX FIFO, and a free-running cycle counter. Reads are combinational, matching the core's same-cycle use of read data; writes take effect at the clock edge.

---
 rtl/mmio_pkg.sv | 23 ++
 rtl/uart_transmitter.sv | 166 ++++++++++++++++
 rtl/mmio_bus.sv | 92 +++++++++
 tb/tb_mmio_bus.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the core memory-port decoder.
//   - MMIO register addresses (byte addresses, bits [1:0] ignored by decode)
//   - STATUS register bit positions
//   - UART transmitter state encoding
package mmio_pkg;

  localparam logic [31:0] TXDATA_ADDR = 32'h1000_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h1000_0004;
  localparam logic [31:0] CYCLE_ADDR  = 32'h1000_0008;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT   = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO feeding an 8N1, LSB-first serial transmitter.
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   i_push         push strobe (one byte per cycle)
//   i_push_data    byte to enqueue
//   i_ovf_clr      clears the sticky overflow flag (a same-cycle overflow wins)
//   o_full         FIFO holds FIFO_DEPTH bytes
//   o_empty        FIFO holds no bytes
//   o_busy         transmitter is not idle
//   o_overflow     sticky: a push was dropped on a full FIFO
//   o_uart_tx      serial line, idles high
module uart_transmitter
  import mmio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BAUD_DIV   = 868
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_ovf_clr,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic       o_overflow,
  output logic       o_uart_tx
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  uart_state_e       r_state, w_state_next;
  logic [BAUD_W-1:0] r_baud, w_baud_next;
  logic [2:0]        r_bit_idx, w_bit_idx_next;
  logic [7:0]        r_shift, w_shift_next;
  logic              r_tx, w_tx_next;

  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count, w_count_next;
  logic              r_full, r_empty, r_busy, r_ovf;

  logic              w_pop, w_push_ok, w_ovf_set, w_baud_done;
  logic [7:0]        w_head;

  assign w_head      = r_fifo[r_rd_ptr];
  assign w_baud_done = (r_baud == BAUD_LAST);

  // Transmitter next-state; a pop always loads the shift register and enters START
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = BAUD_W'(r_baud + 1'b1);
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    case (r_state)
      UART_IDLE: begin
        w_baud_next = '0;
        if (!r_empty) begin
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_state_next = UART_START;
        end
      end
      UART_START: begin
        if (w_baud_done) begin
          w_baud_next    = '0;
          w_bit_idx_next = 3'd0;
          w_state_next   = UART_DATA;
        end
      end
      UART_DATA: begin
        if (w_baud_done) begin
          w_baud_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = UART_STOP;
          end else begin
            w_bit_idx_next = 3'(r_bit_idx + 1'b1);
            w_shift_next   = {1'b0, r_shift[7:1]};
          end
        end
      end
      UART_STOP: begin
        if (w_baud_done) begin
          w_baud_next = '0;
          if (!r_empty) begin
            w_pop        = 1'b1;
            w_shift_next = w_head;
            w_state_next = UART_START;
          end else begin
            w_state_next = UART_IDLE;
          end
        end
      end
      default: begin
        w_baud_next  = '0;
        w_state_next = UART_IDLE;
      end
    endcase

    // Line level is registered from the next state so it changes on the edge
    case (w_state_next)
      UART_START: w_tx_next = 1'b0;
      UART_DATA:  w_tx_next = w_shift_next[0];
      default:    w_tx_next = 1'b1;
    endcase
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot for a push on full
  always_comb begin
    w_push_ok    = i_push && (!r_full || w_pop);
    w_ovf_set    = i_push && r_full && !w_pop;
    w_count_next = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = CNT_W'(r_count + 1'b1);
      2'b01:   w_count_next = CNT_W'(r_count - 1'b1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= UART_IDLE;
      r_baud    <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_tx      <= 1'b1;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_busy    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_count   <= w_count_next;
      r_full    <= (w_count_next == CNT_FULL);
      r_empty   <= (w_count_next == '0);
      r_busy    <= (w_state_next != UART_IDLE);
      r_ovf     <= w_ovf_set | (r_ovf & ~i_ovf_clr);
      if (w_push_ok) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      if (w_pop)     r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
    end
  end

  // FIFO storage is not reset; reset only rewinds the pointers
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= i_push_data;
  end

  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_busy     = r_busy;
  assign o_overflow = r_ovf;
  assign o_uart_tx  = r_tx;

endmodule

// File: rtl/mmio_bus.sv
// mmio_bus: decodes the core's single memory port into word RAM, a UART TX
// FIFO/transmitter and a free-running cycle counter.
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   memory_address        byte address from the core (bits [1:0] ignored)
//   memory_data_out       write data from the core
//   memory_write_enable   write strobe from the core
//   memory_data_in        read data to the core, combinational from address
//   uart_tx               serial output, 8N1, idles high
module mmio_bus
  import mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BAUD_DIV   = 868
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_data_out,
  input  logic        memory_write_enable,
  output logic [31:0] memory_data_in,
  output logic        uart_tx
);

  localparam int unsigned RAM_AW = $clog2(RAM_WORDS);

  logic [31:0]       r_ram [RAM_WORDS];
  logic [31:0]       r_cycle;

  logic              w_ram_sel, w_tx_sel, w_stat_sel, w_cyc_sel;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_full, w_empty, w_busy, w_ovf;
  logic [31:0]       w_status;
  logic              w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^memory_address[1:0];

  // Full 32-bit decode on the word address
  assign w_ram_sel  = (memory_address[31:RAM_AW+2] == '0);
  assign w_ram_idx  = memory_address[RAM_AW+1:2];
  assign w_tx_sel   = (memory_address[31:2] == TXDATA_ADDR[31:2]);
  assign w_stat_sel = (memory_address[31:2] == STATUS_ADDR[31:2]);
  assign w_cyc_sel  = (memory_address[31:2] == CYCLE_ADDR[31:2]);

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (memory_write_enable && w_ram_sel) r_ram[w_ram_idx] <= memory_data_out;
  end

  // Cycle counter; a core write replaces that cycle's increment
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cycle <= 32'h0;
    end else if (memory_write_enable && w_cyc_sel) begin
      r_cycle <= memory_data_out;
    end else begin
      r_cycle <= r_cycle + 32'h1;
    end
  end

  uart_transmitter #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .BAUD_DIV   (BAUD_DIV)
  ) u_uart (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (memory_write_enable && w_tx_sel),
    .i_push_data (memory_data_out[7:0]),
    .i_ovf_clr   (memory_write_enable && w_stat_sel),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_busy      (w_busy),
    .o_overflow  (w_ovf),
    .o_uart_tx   (uart_tx)
  );

  // Read mux; TXDATA and unmapped space read as zero
  always_comb begin
    w_status                 = 32'h0;
    w_status[STAT_FULL_BIT]  = w_full;
    w_status[STAT_EMPTY_BIT] = w_empty;
    w_status[STAT_BUSY_BIT]  = w_busy;
    w_status[STAT_OVF_BIT]   = w_ovf;

    memory_data_in = 32'h0;
    if (w_ram_sel)       memory_data_in = r_ram[w_ram_idx];
    else if (w_stat_sel) memory_data_in = w_status;
    else if (w_cyc_sel)  memory_data_in = r_cycle;
  end

endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: directed and random stimulus for mmio_bus, checked against a
// transaction-level model (RAM array, byte queue with frame timestamps).
module tb_mmio_bus;

  localparam int RW    = 256;
  localparam int FD    = 4;
  localparam int BD    = 4;
  localparam int FRAME = 10 * BD;
  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_CYC = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] memory_address;
  logic [31:0] memory_data_out;
  logic        memory_write_enable;
  logic [31:0] memory_data_in;
  logic        uart_tx;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0]  m_ram [RW];
  bit           m_valid [RW];
  byte unsigned m_q [$];
  bit           m_ovf, m_busy, m_init;
  logic [7:0]   m_cur;
  int           m_e, m_pop_e;
  logic [31:0]  m_cyc;

  always #5 clk = ~clk;

  mmio_bus #(
    .RAM_WORDS  (RW),
    .FIFO_DEPTH (FD),
    .BAUD_DIV   (BD)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .memory_address      (memory_address),
    .memory_data_out     (memory_data_out),
    .memory_write_enable (memory_write_enable),
    .memory_data_in      (memory_data_in),
    .uart_tx             (uart_tx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit read_known(input logic [31:0] a);
    if (a < 32'(RW * 4)) return m_valid[int'(a >> 2)];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] s;
    if (a < 32'(RW * 4)) return m_ram[int'(a >> 2)];
    s = 32'h0;
    if ((a & 32'hFFFF_FFFC) == A_ST) begin
      s[0] = (m_q.size() == FD);
      s[1] = (m_q.size() == 0);
      s[2] = m_busy;
      s[3] = m_ovf;
      return s;
    end
    if ((a & 32'hFFFF_FFFC) == A_CYC) return m_cyc;
    return 32'h0;
  endfunction

  // Line level from the time elapsed since the current byte was popped
  function automatic logic exp_tx();
    int t, idx;
    if (!m_busy) return 1'b1;
    t   = m_e - m_pop_e;
    idx = t / BD;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  task automatic model_edge(input logic rn, input logic [31:0] a, input logic [31:0] d,
                            input logic we);
    bit pop, set, clr, load;
    m_e++;
    if (!rn) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      m_cyc  = 32'h0;
      m_init = 1'b1;
      return;
    end
    pop = 1'b0; set = 1'b0; clr = 1'b0; load = 1'b0;
    if (m_busy && (m_e - m_pop_e == FRAME)) begin
      if (m_q.size() == 0) m_busy = 1'b0;
      else pop = 1'b1;
    end else if (!m_busy && m_q.size() != 0) begin
      pop = 1'b1;
    end
    if (pop) begin
      m_cur   = m_q.pop_front();
      m_busy  = 1'b1;
      m_pop_e = m_e;
    end
    if (we) begin
      if (a < 32'(RW * 4)) begin
        m_ram[int'(a >> 2)]   = d;
        m_valid[int'(a >> 2)] = 1'b1;
      end else if ((a & 32'hFFFF_FFFC) == A_TX) begin
        if (m_q.size() < FD) m_q.push_back(d[7:0]);
        else set = 1'b1;
      end else if ((a & 32'hFFFF_FFFC) == A_ST) begin
        clr = 1'b1;
      end else if ((a & 32'hFFFF_FFFC) == A_CYC) begin
        load = 1'b1;
      end
    end
    m_ovf = set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_cyc = load ? d : m_cyc + 32'h1;
  endtask

  // One clock: drive, check line and read data mid-cycle, then advance model
  task automatic cyc(input logic rn, input logic [31:0] a, input logic [31:0] d, input logic we);
    resetn              = rn;
    memory_address      = a;
    memory_data_out     = d;
    memory_write_enable = we;
    @(negedge clk);
    if (m_init) begin
      chk("uart_tx", 32'(uart_tx), 32'(exp_tx()));
      if (read_known(a)) chk("read", memory_data_in, exp_read(a));
    end
    @(posedge clk);
    model_edge(rn, a, d, we);
    #1;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] v);
    memory_write_enable = 1'b0;
    memory_address      = a;
    #1;
    v = memory_data_in;
  endtask

  initial begin
    logic [31:0] v, a, d;
    logic        we, rn;
    logic [9:0]  fr;
    int          g, k;

    m_init = 1'b0; m_e = 0; m_pop_e = 0; m_busy = 1'b0; m_ovf = 1'b0; m_cyc = 32'h0;

    // Reset state
    repeat (3) cyc(1'b0, A_CYC, 32'h0, 1'b0);
    peek(A_ST, v);  chk("rst_status", v, 32'h2);
    chk("rst_tx", 32'(uart_tx), 32'h1);
    peek(A_CYC, v); chk("rst_cycle", v, 32'h0);

    repeat (10) cyc(1'b1, A_CYC, 32'h0, 1'b0);
    peek(A_CYC, v); chk("cycle_10", v, 32'd10);

    // RAM and unmapped space
    cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    peek(32'h0000_0013, v); chk("ram_rd_13", v, 32'hDEAD_BEEF);
    peek(32'h2000_0000, v); chk("unmapped_rd", v, 32'h0);
    cyc(1'b1, 32'h0000_0000, 32'h0000_1234, 1'b1);
    cyc(1'b1, 32'(RW * 4), 32'hFFFF_0000, 1'b1);
    peek(32'h0000_0000, v); chk("ram_no_alias", v, 32'h0000_1234);
    peek(32'(RW * 4), v);   chk("ram_end_unmapped", v, 32'h0);

    // Cycle counter load and wrap
    cyc(1'b1, A_CYC, 32'hFFFF_FFFE, 1'b1);
    peek(A_CYC, v); chk("cyc_load", v, 32'hFFFF_FFFE);
    cyc(1'b1, A_CYC, 32'h0, 1'b0);
    peek(A_CYC, v); chk("cyc_ff", v, 32'hFFFF_FFFF);
    cyc(1'b1, A_CYC, 32'h0, 1'b0);
    peek(A_CYC, v); chk("cyc_wrap", v, 32'h0);

    // Single 0x55 frame, checked bit by bit
    fr = {1'b1, 8'h55, 1'b0};
    cyc(1'b1, A_TX, 32'h55, 1'b1);
    for (int i = 0; i <= FRAME; i++) begin
      cyc(1'b1, A_ST, 32'h0, 1'b0);
      if (i < FRAME) chk("frame55", 32'(uart_tx), 32'(fr[i / BD]));
      if (i == FRAME / 2) begin peek(A_ST, v); chk("st_mid", v, 32'h6); end
      if (i == FRAME) begin peek(A_ST, v); chk("st_after", v, 32'h2); end
    end

    // Six back-to-back pushes: one pops, four queue, one dropped
    for (int j = 0; j < 6; j++) cyc(1'b1, A_TX, 32'(8'h41 + j), 1'b1);
    peek(A_ST, v); chk("st_full_ovf", v, 32'hD);
    cyc(1'b1, A_ST, 32'h0, 1'b1);
    peek(A_ST, v); chk("st_ovf_clr", v, 32'h5);
    repeat (5 * FRAME + 8) cyc(1'b1, A_ST, 32'h0, 1'b0);
    peek(A_ST, v); chk("st_drained", v, 32'h2);

    // Reset in the middle of a frame with bytes queued
    cyc(1'b1, A_TX, 32'hA5, 1'b1);
    cyc(1'b1, A_TX, 32'h11, 1'b1);
    cyc(1'b1, A_TX, 32'h22, 1'b1);
    repeat (15) cyc(1'b1, A_ST, 32'h0, 1'b0);
    cyc(1'b0, A_ST, 32'h0, 1'b0);
    chk("midrst_tx", 32'(uart_tx), 32'h1);
    peek(A_ST, v); chk("midrst_st", v, 32'h2);
    repeat (2 * FRAME) cyc(1'b1, A_ST, 32'h0, 1'b0);
    chk("midrst_quiet", 32'(uart_tx), 32'h1);

    // Push on a full FIFO coinciding with the STOP->START pop
    for (int j = 0; j < 5; j++) cyc(1'b1, A_TX, 32'(8'h61 + j), 1'b1);
    g = 0;
    while ((m_e + 1 - m_pop_e != FRAME) && g < 100) begin
      cyc(1'b1, A_ST, 32'h0, 1'b0);
      g++;
    end
    chk("sync_bound", 32'(g < 100), 32'h1);
    cyc(1'b1, A_TX, 32'h66, 1'b1);
    peek(A_ST, v); chk("push_on_pop", v, 32'h5);
    repeat (6 * FRAME + 4) cyc(1'b1, A_ST, 32'h0, 1'b0);
    peek(A_ST, v); chk("push_on_pop_done", v, 32'h2);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      k  = $urandom_range(0, 9);
      we = 1'(($urandom_range(0, 1)));
      d  = $urandom;
      case (k)
        0, 1, 2, 3: a = 32'(($urandom_range(0, RW - 1) << 2) | $urandom_range(0, 3));
        4: begin a = A_TX | 32'($urandom_range(0, 3)); we = ($urandom_range(0, 3) == 0); end
        5: begin a = A_ST | 32'($urandom_range(0, 3)); we = ($urandom_range(0, 7) == 0); end
        6: begin a = A_CYC; we = ($urandom_range(0, 15) == 0); end
        7: a = 32'h1000_000C + 32'($urandom_range(0, 3) << 2);
        8: a = 32'(RW * 4) + 32'($urandom_range(0, 63));
        default: a = $urandom;
      endcase
      rn = ($urandom_range(0, 299) != 0);
      if (!rn) we = 1'b0;
      cyc(rn, a, d, we);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
